// File: rtl/reg_scoreboard_if.sv
// Issue / write-back / status bundle between decode, write-back and
// the register scoreboard.
interface reg_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              iss_rd_en;
  logic [NRD*AW-1:0] iss_rs;
  logic [NRD-1:0]    iss_rs_en;
  logic              iss_stall;
  logic [NRD*XLEN-1:0] rs_data;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic [NREG-1:0]   pending;
  logic [AW:0]       pend_cnt;

  modport master (
    output iss_valid, iss_rd, iss_rd_en, iss_rs, iss_rs_en,
    output wb_valid, wb_rd, wb_data, flush,
    input  iss_stall, rs_data, pending, pend_cnt
  );

  modport slave (
    input  iss_valid, iss_rd, iss_rd_en, iss_rs, iss_rs_en,
    input  wb_valid, wb_rd, wb_data, flush,
    output iss_stall, rs_data, pending, pend_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register file with pending-write scoreboard, write-through bypass
// and RAW/WAW issue stall.
module reg_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input logic clk,
  input logic reset,
  reg_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic [NRD*XLEN-1:0] rs_data_c;
  logic [AW-1:0]       rs_a;
  logic                byp;
  logic                src_haz;
  logic                rd_haz;
  logic                stall;
  logic                accept;
  logic                wb_we;

  assign wb_we = bus.wb_valid && (bus.wb_rd != '0);

  always_comb begin
    rs_data_c = '0;
    rs_a      = '0;
    byp       = 1'b0;
    src_haz   = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      rs_a = bus.iss_rs[k*AW +: AW];
      byp  = bus.wb_valid && (bus.wb_rd == rs_a);
      if (rs_a == '0)
        rs_data_c[k*XLEN +: XLEN] = '0;
      else if (byp)
        rs_data_c[k*XLEN +: XLEN] = bus.wb_data;
      else
        rs_data_c[k*XLEN +: XLEN] = regs_q[rs_a];
      if (bus.iss_rs_en[k] && (rs_a != '0) && pend_q[rs_a] && !byp)
        src_haz = 1'b1;
    end
  end

  // A write-back landing this cycle resolves both RAW and WAW on that reg.
  assign rd_haz = bus.iss_rd_en && (bus.iss_rd != '0) &&
                  pend_q[bus.iss_rd] &&
                  !(bus.wb_valid && (bus.wb_rd == bus.iss_rd));
  assign stall  = bus.iss_valid && (src_haz || rd_haz);
  assign accept = bus.iss_valid && !stall && !bus.flush;

  always_comb begin
    pend_d = pend_q;
    if (wb_we)
      pend_d[bus.wb_rd] = 1'b0;
    if (accept && bus.iss_rd_en && (bus.iss_rd != '0))
      pend_d[bus.iss_rd] = 1'b1;
    if (bus.flush)
      pend_d = '0;
    pend_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NREG; i++)
      cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (wb_we)
        regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.iss_stall = stall;
  assign bus.rs_data   = rs_data_c;
  assign bus.pending   = pend_q;
  assign bus.pend_cnt  = cnt_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: bypass, RAW/WAW stall, flush,
// x0 handling and asynchronous reset.
module tb_reg_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  reg_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  reg_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.iss_rd_en = 1'b0;
    bus.iss_rs    = '0;
    bus.iss_rs_en = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = 1'b1;
    bus.iss_rd    = 5'd4;
    #1;
    checks++;
    if (bus.pending !== 32'h0 || bus.pend_cnt !== 6'd0) begin
      $display("FAIL reset_pend: got %h/%0d want 0/0",
               bus.pending, bus.pend_cnt);
      errors++;
    end
    checks++;
    if (bus.iss_stall !== 1'b0) begin
      $display("FAIL reset_stall: got %b want 0", bus.iss_stall);
      errors++;
    end
    cyc();
    reset = 1'b0;
    idle();
    cyc();
  endtask

  task automatic test_bypass();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'hDEADBEEF;
    bus.iss_rs   = {5'd0, 5'd5};
    #1;
    checks++;
    if (bus.rs_data[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL bypass_same: got %h want deadbeef", bus.rs_data[31:0]);
      errors++;
    end
    cyc();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rs    = {5'd0, 5'd5};
    bus.iss_rs_en = 2'b11;
    #1;
    checks++;
    if (bus.rs_data !== {32'h0, 32'hDEADBEEF} || bus.iss_stall !== 1'b0) begin
      $display("FAIL stored_read: got %h stall %b want 00000000deadbeef stall 0",
               bus.rs_data, bus.iss_stall);
      errors++;
    end
    cyc();
    idle();
  endtask

  task automatic test_raw();
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = 1'b1;
    bus.iss_rd    = 5'd7;
    cyc();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rs    = {5'd0, 5'd7};
    bus.iss_rs_en = 2'b01;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b1 || bus.pending[7] !== 1'b1 ||
        bus.pend_cnt !== 6'd1) begin
      $display("FAIL raw_stall: got stall %b p7 %b cnt %0d want 1 1 1",
               bus.iss_stall, bus.pending[7], bus.pend_cnt);
      errors++;
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = 32'h1234;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0 || bus.rs_data[31:0] !== 32'h1234) begin
      $display("FAIL raw_bypass: got stall %b data %h want 0 00001234",
               bus.iss_stall, bus.rs_data[31:0]);
      errors++;
    end
    cyc();
    idle();
    #1;
    checks++;
    if (bus.pending[7] !== 1'b0 || bus.pend_cnt !== 6'd0) begin
      $display("FAIL raw_clear: got p7 %b cnt %0d want 0 0",
               bus.pending[7], bus.pend_cnt);
      errors++;
    end
  endtask

  task automatic test_waw();
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = 1'b1;
    bus.iss_rd    = 5'd3;
    cyc();
    #1;
    checks++;
    if (bus.iss_stall !== 1'b1) begin
      $display("FAIL waw_stall: got %b want 1", bus.iss_stall);
      errors++;
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'hABCD0003;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0) begin
      $display("FAIL waw_wb_stall: got %b want 0", bus.iss_stall);
      errors++;
    end
    cyc();
    idle();
    bus.iss_rs = {5'd0, 5'd3};
    #1;
    checks++;
    if (bus.pending !== 32'h8 || bus.pend_cnt !== 6'd1 ||
        bus.rs_data[31:0] !== 32'hABCD0003) begin
      $display("FAIL waw_issue_wins: got p %h cnt %0d x3 %h want 8 1 abcd0003",
               bus.pending, bus.pend_cnt, bus.rs_data[31:0]);
      errors++;
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'hABCD0003;
    cyc();
    idle();
  endtask

  task automatic test_flush();
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = 1'b1;
    bus.iss_rd    = 5'd1;
    cyc();
    bus.iss_rd = 5'd2;
    cyc();
    bus.iss_rd = 5'd4;
    cyc();
    #1;
    checks++;
    if (bus.pending !== 32'h16 || bus.pend_cnt !== 6'd3) begin
      $display("FAIL b2b_cnt: got p %h cnt %0d want 16 3",
               bus.pending, bus.pend_cnt);
      errors++;
    end
    bus.iss_rd   = 5'd6;
    bus.flush    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd2;
    bus.wb_data  = 32'h77;
    cyc();
    idle();
    bus.iss_rs = {5'd2, 5'd0};
    #1;
    checks++;
    if (bus.pending !== 32'h0 || bus.pend_cnt !== 6'd0) begin
      $display("FAIL flush_clear: got p %h cnt %0d want 0 0",
               bus.pending, bus.pend_cnt);
      errors++;
    end
    checks++;
    if (bus.rs_data[63:32] !== 32'h77) begin
      $display("FAIL flush_wb_data: got %h want 00000077", bus.rs_data[63:32]);
      errors++;
    end
  endtask

  task automatic test_x0();
    idle();
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'hFFFFFFFF;
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = 1'b1;
    bus.iss_rd    = 5'd0;
    bus.iss_rs_en = 2'b11;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0 || bus.rs_data !== 64'h0) begin
      $display("FAIL x0_same: got stall %b data %h want 0 0",
               bus.iss_stall, bus.rs_data);
      errors++;
    end
    cyc();
    idle();
    #1;
    checks++;
    if (bus.pending !== 32'h0 || bus.rs_data !== 64'h0) begin
      $display("FAIL x0_after: got p %h data %h want 0 0",
               bus.pending, bus.rs_data);
      errors++;
    end
  endtask

  task automatic test_multi_port();
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = 1'b1;
    bus.iss_rd    = 5'd9;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd9;
    bus.wb_data   = 32'h55;
    cyc();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rs    = {5'd9, 5'd9};
    bus.iss_rs_en = 2'b10;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b1 || bus.rs_data !== {32'h55, 32'h55}) begin
      $display("FAIL dup_port_hi: got stall %b data %h want 1 both 55",
               bus.iss_stall, bus.rs_data);
      errors++;
    end
    bus.iss_rs_en = 2'b00;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0 || bus.pending[9] !== 1'b1) begin
      $display("FAIL dup_port_none: got stall %b p9 %b want 0 1",
               bus.iss_stall, bus.pending[9]);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    idle();
    #2;
    reset = 1'b1;
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = 1'b1;
    bus.iss_rd    = 5'd9;
    bus.iss_rs    = {5'd9, 5'd9};
    bus.iss_rs_en = 2'b11;
    #1;
    checks++;
    if (bus.pending !== 32'h0 || bus.pend_cnt !== 6'd0 ||
        bus.rs_data !== 64'h0 || bus.iss_stall !== 1'b0) begin
      $display("FAIL async_reset: got p %h cnt %0d data %h stall %b want 0",
               bus.pending, bus.pend_cnt, bus.rs_data, bus.iss_stall);
      errors++;
    end
    #1;
    reset = 1'b0;
    cyc();
    idle();
    #1;
    checks++;
    if (bus.pending !== 32'h200 || bus.pend_cnt !== 6'd1) begin
      $display("FAIL first_issue: got p %h cnt %0d want 200 1",
               bus.pending, bus.pend_cnt);
      errors++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_raw();
    test_waw();
    test_flush();
    test_x0();
    test_multi_port();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
